// File: rtl/dsp48e2_alu.sv
// Behavioural DSP48E2 subset: A:B concat, signed 27x18 multiply, W/X/Y/Z mux and 48-bit ALU.
// Each pipeline stage is present only when its *REG parameter is 1.
module dsp48e2_alu #(
  parameter int          AREG     = 0,
  parameter int          BREG     = 0,
  parameter int          CREG     = 0,
  parameter int          MREG     = 0,
  parameter int          PREG     = 0,
  parameter string       USE_MULT = "NONE",
  parameter logic [47:0] RND      = 48'h0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cea,
  input  logic        ceb,
  input  logic        cec,
  input  logic        cem,
  input  logic        cep,
  input  logic [29:0] a,
  input  logic [17:0] b,
  input  logic [47:0] c,
  input  logic [3:0]  alumode,
  input  logic [8:0]  opmode,
  input  logic [2:0]  carryinsel,
  input  logic        carryin,
  output logic [47:0] p
);
  localparam bit MULT_ON = (USE_MULT == "MULTIPLY");

  logic [29:0] w_a;
  logic [17:0] w_b;
  logic [47:0] w_c, w_m, w_mraw, w_pfb, w_alu;
  logic signed [44:0] w_prod;
  logic [47:0] w_x, w_y, w_z, w_w, w_cin, w_sum;
  logic        w_s;

  // Enables and clock are dead in register-free configurations.
  logic w_unused_ok;
  assign w_unused_ok = ^{clock, reset, cea, ceb, cec, cem, cep};

  generate
    if (AREG == 1) begin : g_areg
      logic [29:0] r_a;
      always_ff @(posedge clock)
        if (reset) r_a <= '0;
        else if (cea) r_a <= a;
      assign w_a = r_a;
    end else begin : g_anoreg
      assign w_a = a;
    end

    if (BREG == 1) begin : g_breg
      logic [17:0] r_b;
      always_ff @(posedge clock)
        if (reset) r_b <= '0;
        else if (ceb) r_b <= b;
      assign w_b = r_b;
    end else begin : g_bnoreg
      assign w_b = b;
    end

    if (CREG == 1) begin : g_creg
      logic [47:0] r_c;
      always_ff @(posedge clock)
        if (reset) r_c <= '0;
        else if (cec) r_c <= c;
      assign w_c = r_c;
    end else begin : g_cnoreg
      assign w_c = c;
    end
  endgenerate

  assign w_prod = $signed(w_a[26:0]) * $signed(w_b);
  assign w_mraw = MULT_ON ? {{3{w_prod[44]}}, w_prod} : 48'h0;

  generate
    if (MREG == 1) begin : g_mreg
      logic [47:0] r_m;
      always_ff @(posedge clock)
        if (reset) r_m <= '0;
        else if (cem) r_m <= w_mraw;
      assign w_m = r_m;
    end else begin : g_mnoreg
      assign w_m = w_mraw;
    end

    // Without a P register there is nothing to feed back, so P reads as 0.
    if (PREG == 1) begin : g_preg
      logic [47:0] r_p;
      always_ff @(posedge clock)
        if (reset) r_p <= '0;
        else if (cep) r_p <= w_alu;
      assign w_pfb = r_p;
      assign p     = r_p;
    end else begin : g_pnoreg
      assign w_pfb = 48'h0;
      assign p     = w_alu;
    end
  endgenerate

  always_comb begin
    w_x = '0;
    w_y = '0;
    w_z = '0;
    w_w = '0;
    // M is only meaningful when both X and Y select it.
    case (opmode[1:0])
      2'b01:   if (opmode[3:0] == 4'b0101) w_x = w_m;
      2'b10:   w_x = w_pfb;
      2'b11:   w_x = {w_a, w_b};
      default: w_x = '0;
    endcase
    case (opmode[3:2])
      2'b10:   w_y = '1;
      2'b11:   w_y = w_c;
      default: w_y = '0;
    endcase
    case (opmode[6:4])
      3'b010, 3'b100: w_z = w_pfb;
      3'b011:         w_z = w_c;
      3'b110:         w_z = 48'($signed(w_pfb) >>> 17);
      default:        w_z = '0;
    endcase
    case (opmode[8:7])
      2'b01:   w_w = w_pfb;
      2'b10:   w_w = RND;
      2'b11:   w_w = w_c;
      default: w_w = '0;
    endcase
  end

  assign w_cin = {47'h0, (carryinsel == 3'b000) & carryin};
  assign w_sum = w_z + w_w + w_x + w_y + w_cin;
  assign w_s   = opmode[3];

  always_comb begin
    w_alu = '0;
    case (alumode)
      4'b0000: w_alu = w_sum;
      4'b0001: w_alu = ~w_z + w_w + w_x + w_y + w_cin;
      4'b0010: w_alu = ~w_sum;
      4'b0011: w_alu = w_z - (w_w + w_x + w_y + w_cin);
      4'b0100, 4'b0111: w_alu = w_s ? ~(w_x ^ w_z) : (w_x ^ w_z);
      4'b0101, 4'b0110: w_alu = w_s ? (w_x ^ w_z) : ~(w_x ^ w_z);
      4'b1100: w_alu = w_s ? (w_x | w_z)  : (w_x & w_z);
      4'b1101: w_alu = w_s ? (w_x | ~w_z) : (w_x & ~w_z);
      4'b1110: w_alu = w_s ? ~(w_x | w_z) : ~(w_x & w_z);
      4'b1111: w_alu = w_s ? (~w_x & w_z) : (~w_x | w_z);
      default: w_alu = '0;
    endcase
  end
endmodule

// File: tb/tb_dsp48e2_alu.sv
// Bench for dsp48e2_alu: directed cases plus randomized checks of a combinational
// and a fully registered instance against a cycle-level reference model.
module tb_dsp48e2_alu;
  localparam logic [47:0] RNDV = 48'h1234_5678_9ABC;

  logic        clk = 1'b0;
  logic        rst, cea, ceb, cec, cem, cep, cin;
  logic [29:0] a;
  logic [17:0] b;
  logic [47:0] c;
  logic [3:0]  alu;
  logic [8:0]  op;
  logic [2:0]  csel;
  logic [47:0] p_comb, p_mult, p_acc, p_inreg, p_full;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  dsp48e2_alu #(.USE_MULT("MULTIPLY"), .RND(RNDV)) u_comb (
    .clock(clk), .reset(rst), .cea(cea), .ceb(ceb), .cec(cec), .cem(cem), .cep(cep),
    .a(a), .b(b), .c(c), .alumode(alu), .opmode(op), .carryinsel(csel), .carryin(cin),
    .p(p_comb));
  dsp48e2_alu #(.MREG(1), .PREG(1), .USE_MULT("MULTIPLY")) u_mult (
    .clock(clk), .reset(rst), .cea(cea), .ceb(ceb), .cec(cec), .cem(cem), .cep(cep),
    .a(a), .b(b), .c(c), .alumode(alu), .opmode(op), .carryinsel(csel), .carryin(cin),
    .p(p_mult));
  dsp48e2_alu #(.PREG(1)) u_acc (
    .clock(clk), .reset(rst), .cea(cea), .ceb(ceb), .cec(cec), .cem(cem), .cep(cep),
    .a(a), .b(b), .c(c), .alumode(alu), .opmode(op), .carryinsel(csel), .carryin(cin),
    .p(p_acc));
  dsp48e2_alu #(.AREG(1), .BREG(1), .CREG(1)) u_inreg (
    .clock(clk), .reset(rst), .cea(cea), .ceb(ceb), .cec(cec), .cem(cem), .cep(cep),
    .a(a), .b(b), .c(c), .alumode(alu), .opmode(op), .carryinsel(csel), .carryin(cin),
    .p(p_inreg));
  dsp48e2_alu #(.AREG(1), .BREG(1), .CREG(1), .MREG(1), .PREG(1),
                .USE_MULT("MULTIPLY"), .RND(RNDV)) u_full (
    .clock(clk), .reset(rst), .cea(cea), .ceb(ceb), .cec(cec), .cem(cem), .cep(cep),
    .a(a), .b(b), .c(c), .alumode(alu), .opmode(op), .carryinsel(csel), .carryin(cin),
    .p(p_full));

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] mul_ref(input logic [29:0] av, input logic [17:0] bv);
    longint sa, sb, pr;
    sa = longint'($signed(av[26:0]));
    sb = longint'($signed(bv));
    pr = sa * sb;
    return pr[47:0];
  endfunction

  // Reference ALU straight from the mode tables; pv is the P feedback value.
  function automatic logic [47:0] alu_ref(input logic [29:0] av, input logic [17:0] bv,
      input logic [47:0] cv, input logic [47:0] mv, input logic [47:0] pv,
      input logic [8:0] o, input logic [3:0] m, input logic [2:0] cs, input logic ci);
    logic [47:0] x, y, z, w, k, ones;
    longint ps;
    bit s;
    ones = '1;
    x = (o[1:0] == 2'd0) ? 48'd0 : (o[1:0] == 2'd1) ? ((o[3:0] == 4'd5) ? mv : 48'd0) :
        (o[1:0] == 2'd2) ? pv : {av, bv};
    y = (o[3:2] == 2'd3) ? cv : (o[3:2] == 2'd2) ? ones : 48'd0;
    ps = longint'($signed(pv)) / 131072;
    if (pv[47] && (pv[16:0] != 0)) ps = ps - 1;   // floor division for negative values
    case (o[6:4])
      3'd2, 3'd4: z = pv;
      3'd3:       z = cv;
      3'd6:       z = ps[47:0];
      default:    z = 48'd0;
    endcase
    w = (o[8:7] == 2'd1) ? pv : (o[8:7] == 2'd2) ? RNDV : (o[8:7] == 2'd3) ? cv : 48'd0;
    k = (cs == 3'd0 && ci) ? 48'd1 : 48'd0;
    s = o[3];
    case (m)
      4'd0:  return z + w + x + y + k;
      4'd1:  return (ones - z) + w + x + y + k;
      4'd2:  return ones - (z + w + x + y + k);
      4'd3:  return z - w - x - y - k;
      4'd4, 4'd7: return s ? ~(x ^ z) : (x ^ z);
      4'd5, 4'd6: return s ? (x ^ z) : ~(x ^ z);
      4'd12: return s ? (x | z) : (x & z);
      4'd13: return s ? (x | ~z) : (x & ~z);
      4'd14: return s ? ~(x | z) : ~(x & z);
      4'd15: return s ? (~x & z) : (~x | z);
      default: return 48'd0;
    endcase
  endfunction

  task automatic rand_in();
    a    = $urandom;
    b    = 18'($urandom);
    c    = {16'($urandom), 32'($urandom)};
    alu  = 4'($urandom);
    op   = 9'($urandom);
    if (alu[2]) op[2] = 1'b0;
    if ($urandom_range(0, 3) == 0) op[3:0] = 4'b0101;
    csel = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom);
    cin  = 1'($urandom);
  endtask

  logic [29:0] ra;
  logic [17:0] rb;
  logic [47:0] rc, rm, rp, nm, np;

  initial begin
    rst = 1'b1; cea = 1'b1; ceb = 1'b1; cec = 1'b1; cem = 1'b1; cep = 1'b1;
    a = 30'h155; b = 18'h2A; c = 48'h77; alu = 4'b0000; op = 9'b000110011;
    csel = 3'd0; cin = 1'b0;
    tick();
    chk("rst_mult", p_mult, 48'h0);
    chk("rst_acc", p_acc, 48'h0);
    chk("rst_inreg", p_inreg, 48'h0);
    chk("rst_full", p_full, 48'h0);
    rst = 1'b0;

    // Combinational directed cases
    a = '1; b = '1; c = 48'h0000_0000_00FF; alu = 4'b1101; op = 9'b000110011; #1;
    chk("not", p_comb, 48'hFFFF_FFFF_FF00);
    a = 0; b = 3; c = 5; alu = 4'b0000; cin = 1'b1; csel = 3'd0; #1;
    chk("add", p_comb, 48'd9);
    alu = 4'b0011; #1;
    chk("sub", p_comb, 48'd1);
    csel = 3'd1; alu = 4'b0000; #1;
    chk("cin_masked", p_comb, 48'd8);
    b = 18'h0F0F0; c = 48'h0000_0000_FF00; alu = 4'b0100; cin = 1'b0; csel = 3'd0; #1;
    chk("xor", p_comb, 48'h0000_0000_0FF0);
    op = 9'b000111011; #1;
    chk("xnor", p_comb, ~48'h0000_0000_0FF0);
    alu = 4'b1001; #1;
    chk("unlisted", p_comb, 48'h0);
    a = 30'h3FFF_FFFD; b = 18'd7; op = 9'b000000101; alu = 4'b0000; #1;
    chk("mul_comb", p_comb, 48'hFFFF_FFFF_FFEB);
    op = 9'b000000001; #1;
    chk("m_half", p_comb, 48'h0);

    for (int i = 0; i < 60; i++) begin
      rand_in(); #1;
      chk("rand_comb", p_comb, alu_ref(a, b, c, mul_ref(a, b), 48'h0, op, alu, csel, cin));
    end

    // Multiply latency through M and P registers
    rst = 1'b1; tick(); rst = 1'b0;
    a = 30'h3FFF_FFFD; b = 18'd7; c = 0; op = 9'b000000101; alu = 4'b0000;
    csel = 3'd0; cin = 1'b0; cem = 1'b1; cep = 1'b1;
    tick();
    chk("mul_lat1", p_mult, 48'h0);
    tick();
    chk("mul_lat2", p_mult, 48'hFFFF_FFFF_FFEB);

    // Accumulate through P feedback
    rst = 1'b1; tick(); rst = 1'b0;
    a = 0; b = 1; op = 9'b000100011; alu = 4'b0000;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("acc_count", p_acc, 48'(i));
    end
    cep = 1'b0; tick();
    chk("acc_hold", p_acc, 48'd3);
    cep = 1'b1; rst = 1'b1; tick();
    chk("acc_rst", p_acc, 48'd0);
    rst = 1'b0; tick();
    chk("acc_restart", p_acc, 48'd1);

    // Input registers only
    rst = 1'b1; tick(); rst = 1'b0;
    a = 0; b = 0; c = 5; op = 9'b000110011; alu = 4'b0000; #1;
    chk("inreg_pre", p_inreg, 48'd0);
    tick();
    chk("inreg_lat", p_inreg, 48'd5);
    c = 9; #1;
    chk("inreg_hold", p_inreg, 48'd5);
    tick();
    chk("inreg_new", p_inreg, 48'd9);
    rst = 1'b1; tick();
    chk("inreg_rst", p_inreg, 48'd0);
    rst = 1'b0;

    // Fully registered instance against a cycle model
    rst = 1'b1; tick(); rst = 1'b0;
    ra = 0; rb = 0; rc = 0; rm = 0; rp = 0;
    for (int i = 0; i < 200; i++) begin
      rand_in();
      rst = ($urandom_range(0, 24) == 0);
      cea = 1'($urandom_range(0, 3) != 0);
      ceb = 1'($urandom_range(0, 3) != 0);
      cec = 1'($urandom_range(0, 3) != 0);
      cem = 1'($urandom_range(0, 3) != 0);
      cep = 1'($urandom_range(0, 3) != 0);
      nm = mul_ref(ra, rb);
      np = alu_ref(ra, rb, rc, rm, rp, op, alu, csel, cin);
      tick();
      if (rst) begin
        ra = 0; rb = 0; rc = 0; rm = 0; rp = 0;
      end else begin
        if (cea) ra = a;
        if (ceb) rb = b;
        if (cec) rc = c;
        if (cem) rm = nm;
        if (cep) rp = np;
      end
      chk("rand_full", p_full, rp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dsp48e2_alu.md
# dsp48e2_alu

Behavioural model of the DSP48E2 slice subset the `prim/ultrascale` primitive wrappers use: A:B concatenation, signed 27×18 multiplier, C input, an OPMODE-driven W/X/Y/Z mux, and a 48-bit ALU with arithmetic and two-input logic modes. It is the simulation and synthesis stand-in for the hard DSP primitive instantiated by wrappers such as the DSP NOT, add and multiply-accumulate cells. Pipeline depth is set per stage by parameters, and a register-free configuration gives a purely combinational P.

## Interface
- AREG, 0, A input register stages (0 or 1)
- BREG, 0, B input register stages (0 or 1)
- CREG, 0, C input register stages (0 or 1)
- MREG, 0, multiplier output register stages (0 or 1)
- PREG, 0, P output register stages (0 or 1)
- USE_MULT, "NONE", "MULTIPLY" enables the M path; "NONE" forces M = 0
- RND, 48'h0, constant selected onto W
- clock  in  1  single clock; all registers update on the rising edge
- reset  in  1  synchronous, active-high; clears every instantiated register (A, B, C, M, P) to 0
- cea, ceb, cec, cem, cep  in  1 each  clock enables for the A, B, C, M and P registers
- a  in  30  A data
- b  in  18  B data
- c  in  48  C data
- alumode  in  4  ALU function, unregistered
- opmode  in  9  mux selects, unregistered: [1:0] X, [3:2] Y, [6:4] Z, [8:7] W
- carryinsel  in  3  carry source select, unregistered
- carryin  in  1  carry input
- p  out  48  result

## Operation
- **Input stages.** A', B', C' are the register outputs when the matching REG=1, otherwise the raw inputs.
- **Multiplier.** M = signed(A'[26:0]) × signed(B'), sign-extended to 48 bits, then registered if MREG=1. When USE_MULT="NONE", M = 0.
- **AB.** AB = {A', B'}, 48 bits.
- **X mux.** 00: 0; 01: M; 10: P; 11: AB.
- **Y mux.** 00: 0; 01: 0 (M partial-product half); 10: all ones; 11: C'.
- **M selection.** M is used only with opmode[3:0] = 0101. Selecting 01 on only one of X or Y contributes 0 on that mux.
- **Z mux.** 000: 0; 001: 0 (no PCIN); 010: P; 011: C'; 100: P; 101: 0; 110: P arithmetically shifted right 17; 111: 0.
- **W mux.** 00: 0; 01: P; 10: RND; 11: C'.
- **P feedback.** "P" in any mux is the P register output. With PREG=0 that value is constant 0.
- **Carry.** CIN = carryin when carryinsel = 000, otherwise 0.
- **Arithmetic (alumode[3:2] = 00), all modulo 2^48:**
  - 0000: Z + W + X + Y + CIN
  - 0001: ~Z + W + X + Y + CIN
  - 0010: ~(Z + W + X + Y + CIN)
  - 0011: Z − (W + X + Y + CIN)
- **Logic (alumode[2] = 1).** Only X and Z are used; W, Y and CIN are ignored. Let s = opmode[3]; opmode[3:2] must be 00 or 10.
  - 0100, 0111: s=0 gives X^Z, s=1 gives ~(X^Z)
  - 0101, 0110: s=0 gives ~(X^Z), s=1 gives X^Z
  - 1100: s=0 gives X&Z, s=1 gives X|Z
  - 1101: s=0 gives X&~Z, s=1 gives X|~Z
  - 1110: s=0 gives ~(X&Z), s=1 gives ~(X|Z)
  - 1111: s=0 gives ~X|Z, s=1 gives ~X&Z
- **Unlisted codes.** Any other alumode code (1000–1011) produces 0.
- **Output.** p = ALU result, registered when PREG=1.

## Timing
- All REG=0: p is combinational in a, b, c and the control inputs; there is no clock dependence.
- Latency, counted in rising edges:
  - A/B path: AREG/BREG + MREG (multiply only) + PREG
  - C path: CREG + PREG
- A register with CE low holds its value.
- reset=1 at a rising edge forces every instantiated register to 0, overriding its CE.
- Output reset value: p = 0 after a reset edge when PREG=1. When PREG=0, p follows the datapath from registered stages (now 0) and live inputs.
- Control inputs take effect in the same cycle they are applied.
- Reset asserted in the middle of an accumulation: p = 0 on the next edge, and accumulation restarts from 0 once reset deasserts.

## Test plan
- **NOT mode.** All REG=0, a=all ones, b=all ones, c=48'h0000_0000_00FF, alumode=1101, opmode=9'b000110011 → p=48'hFFFF_FFFF_FF00 combinationally.
- **Add.** a=0, b=3, c=5, alumode=0000, opmode=9'b000110011, carryin=1, carryinsel=000 → p=9. With alumode=0011 → p=1.
- **Multiply.** USE_MULT="MULTIPLY", MREG=1, PREG=1, cem=cep=1, a=−3, b=7, opmode=9'b000000101 → p=48'hFFFF_FFFF_FFEB two edges after the inputs are applied.
- **Accumulate.** PREG=1, cep=1, a=0, b=1, opmode=9'b000100011, alumode=0000.
  - After a reset edge, p = 1, 2, 3 on successive edges.
  - With cep=0, p holds.
  - Asserting reset for one edge gives p=0, and counting resumes at 1.
- **Logic XOR and XNOR.** a=0, b=18'h0F0F0, c=48'h0_0000_00FF_00, opmode=9'b000110011, alumode=0100 → p=X^Z. Setting opmode[3]=1 (Y=10) yields ~(X^Z).
- **Input-register latency.** AREG=BREG=CREG=1, PREG=0, ce=1, opmode=9'b000110011, alumode=0000 → a change on c appears at p after exactly one edge, and reset clears p to 0.
